// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one request at a time to a variable-latency
// instruction memory, and handles freeze skid, branch redirect and wrong-path squash. Optional FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int                   WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [WORD_LEN-1:0] br_offset,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic                if_valid,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         squash_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [WORD_LEN-1:0]   pc_q, pc_d;
    logic [WORD_LEN-1:0]   addr_q, addr_d;
    logic [WORD_LEN-1:0]   skid_q, skid_d;
    logic                  valid_q, valid_d;
    logic [WORD_LEN-1:0]   instr_q, instr_d;
    logic [WORD_LEN-1:0]   if_pc_q, if_pc_d;

    logic                  fetch_s;
    logic                  hit_s;
    logic [WORD_LEN-1:0]   pc_inc_s;
    logic [WORD_LEN-1:0]   target_s;

    // req_q is low only in the first cycle after reset, so a stale ready is ignored there
    assign fetch_s  = (state_q == ST_REQ) && req_q;
    assign hit_s    = fetch_s && imem_ready;
    assign pc_inc_s = pc_q + WORD_LEN'(4);
    assign target_s = pc_q + {br_offset[WORD_LEN-3:0], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect takes priority over freeze and ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (br_taken) begin
                    state_d = (fetch_s && !imem_ready) ? ST_DROP : ST_REQ;
                end else if (hit_s && freeze) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (br_taken || !freeze) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (imem_ready) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        req_d   = (state_d != ST_HOLD);
        skid_d  = skid_q;
        valid_d = valid_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        if (br_taken) begin
            pc_d = target_s;
        end else if (hit_s) begin
            pc_d = pc_inc_s;
        end else begin
            pc_d = pc_q;
        end
        // DROP keeps presenting the abandoned address until memory answers
        addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
        if (br_taken) begin
            valid_d = 1'b0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (hit_s && freeze) begin
                        skid_d = imem_rdata;
                    end else if (hit_s) begin
                        instr_d = imem_rdata;
                        if_pc_d = pc_inc_s;
                        valid_d = 1'b1;
                    end else if (!freeze) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                end
                ST_HOLD: begin
                    // pc_q already points past the skid word, so it is the skid word's pc+4
                    if (!freeze) begin
                        instr_d = skid_q;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = valid_q;
                    end
                end
                ST_DROP: valid_d = 1'b0;
                default: valid_d = 1'b0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            skid_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            if_pc_q <= '0;
        end else begin
            req_q   <= req_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_valid    = valid_q;
    assign instruction = instr_q;
    assign if_pc       = if_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] squash_cnt_q;
    logic        stall_s;
    logic        squash_s;

    assign stall_s  = req_q && !imem_ready;
    assign squash_s = (br_taken && (hit_s || (state_q == ST_HOLD)))
                   || ((state_q == ST_DROP) && imem_ready);

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (squash_s && (squash_cnt_q != 32'hFFFF_FFFF)) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end else begin
                squash_cnt_q <= squash_cnt_q;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, slow memory, freeze skid, redirects and reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_offset = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] squash_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    fetch_sequencer #(.WORD_LEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .br_offset(br_offset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .instruction(instruction), .if_pc(if_pc)
`ifdef FETCH_PERF_EN
        , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one cycle; afterwards imem_req=1 at RESET_PC
    task automatic apply_reset();
        rst = 1'b1; freeze = 1'b0; br_taken = 1'b0; br_offset = 32'd0; imem_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instruction); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc got %h want 0", if_pc); end
        rst = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got %b/%h want 1/0", imem_req, imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL late_ready_ignored got %b want 0", if_valid); end
    endtask

    task automatic test_stream();
        apply_reset();
        imem_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || instruction !== word_at(32'(4*k-4)) || if_pc !== 32'(4*k) || imem_addr !== 32'(4*k)) begin
                n_fail++;
                $display("FAIL stream[%0d] got v=%b i=%h pc=%h a=%h want v=1 i=%h pc=%h a=%h", k, if_valid, instruction,
                         if_pc, imem_addr, word_at(32'(4*k-4)), 32'(4*k), 32'(4*k));
            end
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_slow_mem();
        logic [31:0] exp_addr;
        logic        rdy;
        int          pulses;
        apply_reset();
        exp_addr = 32'h0;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            rdy = (i % 3 == 2);
            imem_ready = rdy;
            n_checks++;
            if (imem_addr !== exp_addr || imem_req !== 1'b1) begin
                n_fail++; $display("FAIL slow_addr[%0d] got %h req=%b want %h req=1", i, imem_addr, imem_req, exp_addr);
            end
            tick();
            if (if_valid === 1'b1) pulses++;
            n_checks++;
            if (rdy && (if_valid !== 1'b1 || instruction !== word_at(exp_addr) || if_pc !== exp_addr + 32'd4)) begin
                n_fail++; $display("FAIL slow_word[%0d] got v=%b i=%h pc=%h want v=1 i=%h pc=%h", i, if_valid,
                                   instruction, if_pc, word_at(exp_addr), exp_addr + 32'd4);
            end else if (!rdy && if_valid !== 1'b0) begin
                n_fail++; $display("FAIL slow_bubble[%0d] got v=%b want 0", i, if_valid);
            end
            if (rdy) exp_addr = exp_addr + 32'd4;
        end
        imem_ready = 1'b0;
        n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL slow_pulses got %0d want 3", pulses); end
    endtask

    task automatic test_freeze();
        apply_reset();
        imem_ready = 1'b1;
        tick(); tick();
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || instruction !== word_at(32'h4) || if_pc !== 32'h8 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL freeze_hold[%0d] got v=%b i=%h pc=%h req=%b want v=1 i=%h pc=8 req=0",
                                   i, if_valid, instruction, if_pc, imem_req, word_at(32'h4));
            end
        end
        freeze = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || instruction !== word_at(32'h8) || if_pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            n_fail++; $display("FAIL freeze_skid got v=%b i=%h pc=%h req=%b a=%h want v=1 i=%h pc=c req=1 a=c",
                               if_valid, instruction, if_pc, imem_req, imem_addr, word_at(32'h8));
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || instruction !== word_at(32'hC) || if_pc !== 32'h10) begin
            n_fail++; $display("FAIL freeze_resume got v=%b i=%h pc=%h want v=1 i=%h pc=10", if_valid, instruction, if_pc, word_at(32'hC));
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_redirect_drop();
        apply_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL drop_setup got %h want 40", imem_addr); end
        br_taken = 1'b1; br_offset = 32'hFFFF_FFFC; imem_ready = 1'b0;
        tick();
        br_taken = 1'b0; br_offset = 32'd0;
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL drop_enter got v=%b req=%b a=%h want v=0 req=1 a=40", if_valid, imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL drop_wait got v=%b a=%h want v=0 a=40", if_valid, imem_addr);
        end
        imem_ready = 1'b1;
        tick();
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h30) begin
            n_fail++; $display("FAIL drop_discard got v=%b req=%b a=%h want v=0 req=1 a=30", if_valid, imem_req, imem_addr);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || instruction !== word_at(32'h30) || if_pc !== 32'h34) begin
            n_fail++; $display("FAIL drop_target got v=%b i=%h pc=%h want v=1 i=%h pc=34", if_valid, instruction, if_pc, word_at(32'h30));
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_redirect_ready();
        apply_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        br_taken = 1'b1; br_offset = 32'd3;
        tick();
        br_taken = 1'b0; br_offset = 32'd0;
        n_checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h1C) begin
            n_fail++; $display("FAIL br_ready got v=%b a=%h want v=0 a=1c", if_valid, imem_addr);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || instruction !== word_at(32'h1C) || if_pc !== 32'h20) begin
            n_fail++; $display("FAIL br_target got v=%b i=%h pc=%h want v=1 i=%h pc=20", if_valid, instruction, if_pc, word_at(32'h1C));
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drop();
        apply_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        imem_ready = 1'b0; br_taken = 1'b1; br_offset = 32'd8;
        tick();
        br_taken = 1'b0;
        rst = 1'b1; imem_ready = 1'b0;
        tick();
        n_checks++;
        if (imem_addr !== 32'h0 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop got a=%h v=%b req=%b want a=0 v=0 req=0", imem_addr, if_valid, imem_req);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || squash_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cnt, squash_cnt);
        end
`endif
        rst = 1'b0; imem_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_restart got req=%b a=%h v=%b want 1/0/0", imem_req, imem_addr, if_valid);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || instruction !== word_at(32'h0) || if_pc !== 32'h4) begin
            n_fail++; $display("FAIL rst_first_word got v=%b i=%h pc=%h want v=1 i=%h pc=4", if_valid, instruction, if_pc, word_at(32'h0));
        end
        imem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_slow_mem();
        test_freeze();
        test_redirect_drop();
        test_redirect_ready();
        test_reset_mid_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
